// File: rtl/clock_set_ctrl_if.sv
// Key-event inputs and mode/adjust/display outputs of the clock mode/time-setting controller.
interface clock_set_ctrl_if;
  logic       Key_mode_p;
  logic       Key_up;
  logic       Key_dn;
  logic       Tick_1s;
  logic       Run_en;
  logic [1:0] Mode;
  logic       Adj_up;
  logic       Adj_dn;
  logic       Sec_clr;
  logic       Blink;
  logic [3:0] LED;

  modport master (
    output Key_mode_p, Key_up, Key_dn, Tick_1s,
    input  Run_en, Mode, Adj_up, Adj_dn, Sec_clr, Blink, LED
  );

  modport slave (
    input  Key_mode_p, Key_up, Key_dn, Tick_1s,
    output Run_en, Mode, Adj_up, Adj_dn, Sec_clr, Blink, LED
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock mode/time-setting controller: RUN plus three SET modes, press and hold-to-repeat
// adjust pulses, idle timeout back to RUN, blink enable for the selected digits and mode LEDs.
module clock_set_ctrl #(
  parameter int MCNT_HOLD  = 50_000_000,
  parameter int MCNT_REP   = 10_000_000,
  parameter int MCNT_BLINK = 25_000_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  clock_set_ctrl_if.slave   bus
);

  localparam int HW = (MCNT_HOLD > 1) ? $clog2(MCNT_HOLD) : 1;
  localparam int BW = (MCNT_BLINK > 1) ? $clog2(MCNT_BLINK) : 1;
  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam logic [HW-1:0] HOLD_TC  = HW'(MCNT_HOLD - 1);
  localparam logic [HW-1:0] REP_TC   = HW'(MCNT_REP - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(MCNT_BLINK - 1);
  localparam logic [IW-1:0] IDLE_TC  = IW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET_H = 2'd1,
    S_SET_M = 2'd2,
    S_SET_S = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_armed, r_up_prev, r_dn_prev;
  logic            r_hold_act, r_hold_up, r_hold_rep;
  logic [HW-1:0]   r_hold_cnt;
  logic [IW-1:0]   r_idle;
  logic [BW-1:0]   r_bcnt;
  logic            r_blink, r_run_en, r_adj_up, r_adj_dn, r_sec_clr;
  logic [3:0]      r_led;

  logic            w_hold_act_nxt, w_hold_up_nxt, w_hold_rep_nxt;
  logic [HW-1:0]   w_hold_cnt_nxt;
  logic [IW-1:0]   w_idle_nxt;
  logic [BW-1:0]   w_bcnt_nxt;
  logic            w_blink_nxt, w_adj_up, w_adj_dn, w_sec_clr;
  logic            w_up_press, w_dn_press, w_both, w_any, w_hold_key, w_pulse;

  // r_armed blocks the first post-reset sample so a key held through reset is not a press
  assign w_both     = bus.Key_up & bus.Key_dn;
  assign w_any      = bus.Key_up | bus.Key_dn;
  assign w_up_press = bus.Key_up & ~r_up_prev & r_armed & ~bus.Key_dn;
  assign w_dn_press = bus.Key_dn & ~r_dn_prev & r_armed & ~bus.Key_up;
  assign w_hold_key = r_hold_up ? bus.Key_up : bus.Key_dn;
  assign w_pulse    = w_adj_up | w_adj_dn | w_sec_clr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_act_nxt = r_hold_act;
    w_hold_up_nxt  = r_hold_up;
    w_hold_rep_nxt = r_hold_rep;
    w_hold_cnt_nxt = r_hold_cnt;
    w_idle_nxt     = r_idle;
    w_blink_nxt    = r_blink;
    w_bcnt_nxt     = r_bcnt;
    w_adj_up       = 1'b0;
    w_adj_dn       = 1'b0;
    w_sec_clr      = 1'b0;

    // A mode change takes priority and drops any adjust seen in the same cycle
    if (bus.Key_mode_p) begin
      w_state_nxt    = state_t'(r_state + 2'd1);
      w_hold_act_nxt = 1'b0;
      w_hold_cnt_nxt = '0;
    end else if (r_state == S_RUN || w_both) begin
      w_hold_act_nxt = 1'b0;
      w_hold_cnt_nxt = '0;
    end else if (w_up_press || w_dn_press) begin
      if (r_state == S_SET_S) begin
        w_sec_clr = 1'b1;
      end else begin
        w_adj_up       = w_up_press;
        w_adj_dn       = w_dn_press;
        w_hold_act_nxt = 1'b1;
        w_hold_up_nxt  = w_up_press;
        w_hold_rep_nxt = 1'b0;
        w_hold_cnt_nxt = '0;
      end
    end else if (r_hold_act) begin
      if (!w_hold_key) begin
        w_hold_act_nxt = 1'b0;
        w_hold_cnt_nxt = '0;
      end else if (r_hold_cnt == (r_hold_rep ? REP_TC : HOLD_TC)) begin
        w_adj_up       = r_hold_up;
        w_adj_dn       = ~r_hold_up;
        w_hold_rep_nxt = 1'b1;
        w_hold_cnt_nxt = '0;
      end else begin
        w_hold_cnt_nxt = r_hold_cnt + HW'(1);
      end
    end

    if (bus.Key_mode_p || w_any || r_state == S_RUN) begin
      w_idle_nxt = '0;
    end else if (bus.Tick_1s) begin
      if (r_idle == IDLE_TC) begin
        w_idle_nxt  = '0;
        w_state_nxt = S_RUN;
      end else begin
        w_idle_nxt = r_idle + IW'(1);
      end
    end

    // Digits stay lit in RUN, on mode entry, while a key is held and while adjusting
    if (w_state_nxt == S_RUN || w_state_nxt != r_state || w_any || w_pulse) begin
      w_blink_nxt = 1'b1;
      w_bcnt_nxt  = '0;
    end else if (r_bcnt == BLINK_TC) begin
      w_blink_nxt = ~r_blink;
      w_bcnt_nxt  = '0;
    end else begin
      w_bcnt_nxt = r_bcnt + BW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_armed    <= 1'b0;
      r_up_prev  <= 1'b0;
      r_dn_prev  <= 1'b0;
      r_hold_act <= 1'b0;
      r_hold_up  <= 1'b0;
      r_hold_rep <= 1'b0;
      r_hold_cnt <= '0;
      r_idle     <= '0;
      r_bcnt     <= '0;
      r_blink    <= 1'b1;
      r_run_en   <= 1'b1;
      r_adj_up   <= 1'b0;
      r_adj_dn   <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_led      <= 4'b0001;
    end else begin
      r_armed    <= 1'b1;
      r_up_prev  <= bus.Key_up;
      r_dn_prev  <= bus.Key_dn;
      r_hold_act <= w_hold_act_nxt;
      r_hold_up  <= w_hold_up_nxt;
      r_hold_rep <= w_hold_rep_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_idle     <= w_idle_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_blink    <= w_blink_nxt;
      r_run_en   <= (w_state_nxt == S_RUN);
      r_adj_up   <= w_adj_up;
      r_adj_dn   <= w_adj_dn;
      r_sec_clr  <= w_sec_clr;
      r_led      <= 4'b0001 << w_state_nxt;
    end
  end

  assign bus.Run_en  = r_run_en;
  assign bus.Mode    = r_state;
  assign bus.Adj_up  = r_adj_up;
  assign bus.Adj_dn  = r_adj_dn;
  assign bus.Sec_clr = r_sec_clr;
  assign bus.Blink   = r_blink;
  assign bus.LED     = r_led;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: cycle-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_clock_set_ctrl;
  localparam int HOLD = 10;
  localparam int REP  = 4;
  localparam int BLK  = 5;
  localparam int TO   = 3;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  clock_set_ctrl_if ifc();

  clock_set_ctrl #(
    .MCNT_HOLD (HOLD),
    .MCNT_REP  (REP),
    .MCNT_BLINK(BLK),
    .TIMEOUT_S (TO)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (ifc)
  );

  always #5 Clk = ~Clk;

  // Reference model: ages and tick counts since events, evaluated on each sampling edge
  int         m_mode = 0, m_age = 0, m_idle = 0, m_b = 0, nmode;
  bit         m_hold = 0, m_hup = 0, m_up_prev = 0, m_dn_prev = 0, m_up_ok = 0, m_dn_ok = 0;
  bit         u, d, mp, tk, ue, de, pu, pd, ps;
  bit         e_run = 1, e_up = 0, e_dn = 0, e_sc = 0, e_blink = 1;
  logic [1:0] e_mode = 2'd0;
  logic [3:0] e_led = 4'b0001;

  initial forever begin
    @(posedge Clk or posedge Reset);
    if (Reset) begin
      m_mode = 0; m_age = 0; m_idle = 0; m_b = 0;
      m_hold = 0; m_hup = 0; m_up_prev = 0; m_dn_prev = 0; m_up_ok = 0; m_dn_ok = 0;
      e_run = 1; e_up = 0; e_dn = 0; e_sc = 0; e_blink = 1; e_mode = 2'd0; e_led = 4'b0001;
    end else begin
      u = ifc.Key_up; d = ifc.Key_dn; mp = ifc.Key_mode_p; tk = ifc.Tick_1s;
      ue = u && !m_up_prev && m_up_ok;
      de = d && !m_dn_prev && m_dn_ok;
      pu = 0; pd = 0; ps = 0;
      nmode = m_mode;
      if (mp) begin
        nmode = (m_mode + 1) % 4;
        m_hold = 0;
      end else if (m_mode == 0 || (u && d)) begin
        m_hold = 0;
      end else if (ue || de) begin
        if (m_mode == 3) begin
          ps = 1;
        end else begin
          pu = ue; pd = de; m_hold = 1; m_hup = ue; m_age = 0;
        end
      end else if (m_hold) begin
        if (m_hup ? u : d) begin
          m_age++;
          if (m_age >= HOLD && ((m_age - HOLD) % REP) == 0) begin
            pu = m_hup; pd = !m_hup;
          end
        end else begin
          m_hold = 0;
        end
      end
      if (mp || u || d || m_mode == 0) begin
        m_idle = 0;
      end else if (tk) begin
        m_idle++;
        if (m_idle == TO) begin
          nmode = 0; m_idle = 0;
        end
      end
      if (nmode == 0 || nmode != m_mode || u || d || pu || pd || ps) m_b = 0;
      else m_b++;
      m_mode = nmode;
      m_up_prev = u; m_dn_prev = d;
      if (!u) m_up_ok = 1;
      if (!d) m_dn_ok = 1;
      e_mode  = 2'(nmode);
      e_run   = (nmode == 0);
      e_led   = 4'b0001 << nmode;
      e_up = pu; e_dn = pd; e_sc = ps;
      e_blink = ((m_b / BLK) % 2) == 0;
    end
  end

  logic [10:0] got_v, exp_v;
  initial forever begin
    @(negedge Clk);
    got_v = {ifc.Run_en, ifc.Mode, ifc.Adj_up, ifc.Adj_dn, ifc.Sec_clr, ifc.Blink, ifc.LED};
    exp_v = {e_run, e_mode, e_up, e_dn, e_sc, e_blink, e_led};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t run/mode/up/dn/clr/blink/led got=%b required=%b", $time, got_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mode_pulse();
    ifc.Key_mode_p = 1'b1;
    @(negedge Clk);
    ifc.Key_mode_p = 1'b0;
  endtask

  task automatic tick(input int gap);
    repeat (gap - 1) @(negedge Clk);
    ifc.Tick_1s = 1'b1;
    @(negedge Clk);
    ifc.Tick_1s = 1'b0;
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      if (ifc.Adj_up || ifc.Adj_dn || ifc.Sec_clr) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  logic [63:0] mask, exp_mask;
  int ndn, nclr, first, nadj, cnt;

  initial begin
    ifc.Key_mode_p = 1'b0; ifc.Key_up = 1'b0; ifc.Key_dn = 1'b0; ifc.Tick_1s = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_mode", ifc.Mode, 0);
    chk("rst_led", ifc.LED, 4'b0001);
    chk("rst_run_en", ifc.Run_en, 1);
    chk("rst_blink", ifc.Blink, 1);
    chk("rst_pulses", {ifc.Adj_up, ifc.Adj_dn, ifc.Sec_clr}, 0);
    #2 Reset = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      repeat (19) @(negedge Clk);
      mode_pulse();
      chk("mode_seq", ifc.Mode, i % 4);
      chk("led_seq", ifc.LED, 64'd1 << (i % 4));
      chk("run_en_seq", ifc.Run_en, (i % 4) == 0);
    end

    // SET_H: hold up through sample 30, release, then watch blink
    mode_pulse();
    repeat (5) @(negedge Clk);
    mask = '0; ndn = 0;
    exp_mask = (64'd1 << 1) | (64'd1 << 11) | (64'd1 << 15) | (64'd1 << 19) |
               (64'd1 << 23) | (64'd1 << 27) | (64'd1 << 31);
    ifc.Key_up = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge Clk);
      if (ifc.Adj_up) mask[k] = 1'b1;
      if (ifc.Adj_dn) ndn++;
      if (k == 20) chk("blink_held", ifc.Blink, 1);
      if (k == 35) chk("blink_on", ifc.Blink, 1);
      if (k == 36) chk("blink_off", ifc.Blink, 0);
      if (k == 41) chk("blink_back", ifc.Blink, 1);
      if (k == 31) ifc.Key_up = 1'b0;
    end
    chk("repeat_cycles", mask, exp_mask);
    chk("repeat_no_dn", ndn, 0);

    // SET_S: a held dn key clears seconds once
    mode_pulse(); mode_pulse();
    chk("set_s_mode", ifc.Mode, 3);
    repeat (3) @(negedge Clk);
    nclr = 0; first = 0; nadj = 0;
    ifc.Key_dn = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge Clk);
      if (ifc.Sec_clr) begin
        nclr++;
        if (first == 0) first = k;
      end
      if (ifc.Adj_up || ifc.Adj_dn) nadj++;
      if (k == 30) ifc.Key_dn = 1'b0;
    end
    chk("sec_clr_count", nclr, 1);
    chk("sec_clr_at", first, 1);
    chk("set_s_no_adj", nadj, 0);

    // Idle timeout in SET_M
    mode_pulse();
    chk("back_to_run", ifc.Mode, 0);
    mode_pulse(); mode_pulse();
    chk("set_m_mode", ifc.Mode, 2);
    tick(50); chk("to_tick1", ifc.Mode, 2);
    tick(50); chk("to_tick2", ifc.Mode, 2);
    tick(50); chk("to_tick3", ifc.Mode, 0);

    // Timeout restarts after a tap between ticks 2 and 3
    mode_pulse(); mode_pulse();
    tick(50); tick(50);
    chk("tap_pre", ifc.Mode, 2);
    repeat (10) @(negedge Clk);
    ifc.Key_up = 1'b1;
    repeat (3) @(negedge Clk);
    ifc.Key_up = 1'b0;
    tick(50); chk("tap_tick1", ifc.Mode, 2);
    tick(50); chk("tap_tick2", ifc.Mode, 2);
    tick(50); chk("tap_tick3", ifc.Mode, 0);

    // Both keys together in SET_H
    mode_pulse();
    repeat (3) @(negedge Clk);
    ifc.Key_up = 1'b1; ifc.Key_dn = 1'b1;
    count_pulses(25, cnt);
    chk("both_keys_no_pulse", cnt, 0);
    ifc.Key_up = 1'b0; ifc.Key_dn = 1'b0;
    repeat (3) @(negedge Clk);

    // Mode key coincident with an up press edge
    ifc.Key_mode_p = 1'b1; ifc.Key_up = 1'b1;
    @(negedge Clk);
    ifc.Key_mode_p = 1'b0;
    chk("coinc_mode", ifc.Mode, 2);
    chk("coinc_no_adj", ifc.Adj_up, 0);
    count_pulses(20, cnt);
    chk("coinc_no_repeat", cnt, 0);
    ifc.Key_up = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset during the repeat phase with the key still held
    mode_pulse(); mode_pulse(); mode_pulse();
    chk("pre_reset_mode", ifc.Mode, 1);
    repeat (3) @(negedge Clk);
    ifc.Key_up = 1'b1;
    repeat (14) @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_mode", ifc.Mode, 0);
    chk("mid_rst_led", ifc.LED, 4'b0001);
    chk("mid_rst_run_en", ifc.Run_en, 1);
    chk("mid_rst_blink", ifc.Blink, 1);
    chk("mid_rst_adj", ifc.Adj_up, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    mode_pulse();
    chk("post_rst_mode", ifc.Mode, 1);
    count_pulses(20, cnt);
    chk("held_through_reset", cnt, 0);
    ifc.Key_up = 1'b0;
    repeat (5) @(negedge Clk);
    ifc.Key_up = 1'b1;
    @(negedge Clk);
    chk("fresh_press", ifc.Adj_up, 1);
    repeat (3) @(negedge Clk);
    ifc.Key_up = 1'b0;
    repeat (5) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
